// File: rtl/bcd_display_mux.sv
// bcd_display_mux: captures a 3-digit BCD value and time-multiplexes it onto a
// common-anode 7-segment display, with dead time between digit slots.
// Optional feature macro: BCD_DISP_LZB_EN (leading-zero blanking of tens/hundreds).
module bcd_display_mux #(
  parameter int unsigned REFRESH_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       clr,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       disp_valid,
  output logic       bcd_err
);

  localparam int unsigned CNT_W = $clog2(REFRESH_CYCLES);
  localparam logic [CNT_W-1:0] LAST_SHOW = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SHOW0, GAP0, SHOW1, GAP1, SHOW2, GAP2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_ones, r_tens, r_hundreds;
  logic             r_valid, r_err;
  logic [6:0]       r_seg, w_seg_nxt;
  logic [2:0]       r_an, w_an_nxt;
  logic             w_slot_done;
  logic             w_gap_done;

  // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal values show a dash.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h40;
      4'd1:    p = 7'h79;
      4'd2:    p = 7'h24;
      4'd3:    p = 7'h30;
      4'd4:    p = 7'h19;
      4'd5:    p = 7'h12;
      4'd6:    p = 7'h02;
      4'd7:    p = 7'h78;
      4'd8:    p = 7'h00;
      4'd9:    p = 7'h10;
      default: p = 7'h3F;
    endcase
    return p;
  endfunction

  assign w_slot_done = (r_cnt == LAST_SHOW);
  assign w_gap_done  = (r_cnt == LAST_GAP);

  // State and slot-counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: fixed-length show/gap slots cycling ones -> tens -> hundreds.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    if (clr) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_cnt_nxt = '0;
          if (load) w_state_nxt = SHOW0;
        end
        SHOW0: if (w_slot_done) begin w_state_nxt = GAP0;  w_cnt_nxt = '0; end
        GAP0:  if (w_gap_done)  begin w_state_nxt = SHOW1; w_cnt_nxt = '0; end
        SHOW1: if (w_slot_done) begin w_state_nxt = GAP1;  w_cnt_nxt = '0; end
        GAP1:  if (w_gap_done)  begin w_state_nxt = SHOW2; w_cnt_nxt = '0; end
        SHOW2: if (w_slot_done) begin w_state_nxt = GAP2;  w_cnt_nxt = '0; end
        GAP2:  if (w_gap_done)  begin w_state_nxt = SHOW0; w_cnt_nxt = '0; end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Digit/anode decode of the current state; idle and gap slots stay dark.
  always_comb begin
    w_an_nxt  = 3'b111;
    w_seg_nxt = 7'h7F;
    case (r_state)
      SHOW0: begin
        w_an_nxt  = 3'b110;
        w_seg_nxt = f_seg(r_ones);
      end
      SHOW1: begin
        w_an_nxt  = 3'b101;
        w_seg_nxt = f_seg(r_tens);
`ifdef BCD_DISP_LZB_EN
        if (r_hundreds == 4'd0 && r_tens == 4'd0) begin
          w_an_nxt  = 3'b111;
          w_seg_nxt = 7'h7F;
        end
`endif
      end
      SHOW2: begin
        w_an_nxt  = 3'b011;
        w_seg_nxt = f_seg(r_hundreds);
`ifdef BCD_DISP_LZB_EN
        if (r_hundreds == 4'd0) begin
          w_an_nxt  = 3'b111;
          w_seg_nxt = 7'h7F;
        end
`endif
      end
      default: ;
    endcase
  end

  // Registered display outputs; a clear blanks them on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an  <= 3'b111;
      r_seg <= 7'h7F;
    end else if (clr) begin
      r_an  <= 3'b111;
      r_seg <= 7'h7F;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  // Shadow capture of the digits plus valid/error flags; clear wins over load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ones     <= 4'd0;
      r_tens     <= 4'd0;
      r_hundreds <= 4'd0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else if (clr) begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (load) begin
      r_ones     <= ones;
      r_tens     <= tens;
      r_hundreds <= hundreds;
      r_valid    <= 1'b1;
      r_err      <= (ones > 4'd9) || (tens > 4'd9) || (hundreds > 4'd9);
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign disp_valid = r_valid;
  assign bcd_err    = r_err;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Bench for bcd_display_mux with REFRESH_CYCLES=4, GAP_CYCLES=2. The reference
// model tracks cycles elapsed since the scan started and derives slot/offset
// arithmetically. Honours BCD_DISP_LZB_EN when defined.
module tb_bcd_display_mux;

  localparam int R = 4;
  localparam int G = 2;
  localparam int S = R + G;
  localparam int P = 3 * S;

  logic       clk = 1'b0;
  logic       reset, load, clr;
  logic [3:0] ones, tens, hundreds;
  logic [6:0] seg;
  logic [2:0] an;
  logic       disp_valid, bcd_err;

  bcd_display_mux #(.REFRESH_CYCLES(R), .GAP_CYCLES(G)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .clr        (clr),
    .seg        (seg),
    .an         (an),
    .disp_valid (disp_valid),
    .bcd_err    (bcd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  bit m_active;
  int m_j;
  int m_d [3];
  bit m_valid, m_err;

  int exp_an_seq [18] = '{6,6,6,6,7,7,5,5,5,5,7,7,3,3,3,3,7,7};

  function automatic logic [6:0] ref_pat(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_j = 0; m_valid = 0; m_err = 0;
    m_d[0] = 0; m_d[1] = 0; m_d[2] = 0;
  endtask

  // What the display should show given the model state before an edge.
  task automatic model_view(output logic [2:0] ea, output logic [6:0] es);
    int ph, slot, off;
    bit lit;
    ea = 3'b111; es = 7'h7F;
    if (m_active) begin
      ph   = m_j % P;
      slot = ph / S;
      off  = ph % S;
      lit  = (off < R);
`ifdef BCD_DISP_LZB_EN
      if (slot == 2 && m_d[2] == 0) lit = 0;
      if (slot == 1 && m_d[2] == 0 && m_d[1] == 0) lit = 0;
`endif
      if (lit) begin
        ea = ~(3'(1) << slot);
        es = ref_pat(m_d[slot]);
      end
    end
  endtask

  // One clock with the currently driven inputs; checks all outputs after the edge.
  task automatic tick();
    logic [2:0] ea;
    logic [6:0] es;
    if (reset) begin
      ea = 3'b111; es = 7'h7F;
      model_reset();
    end else if (clr) begin
      ea = 3'b111; es = 7'h7F;
      m_active = 0; m_j = 0; m_valid = 0; m_err = 0;
    end else begin
      model_view(ea, es);
      if (m_active) m_j = (m_j + 1) % P;
      if (load) begin
        m_d[0] = int'(ones); m_d[1] = int'(tens); m_d[2] = int'(hundreds);
        m_valid = 1;
        m_err = (ones > 9) || (tens > 9) || (hundreds > 9);
        if (!m_active) begin
          m_active = 1;
          m_j = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    check("an", 32'(an), 32'(ea));
    check("seg", 32'(seg), 32'(es));
    check("disp_valid", 32'(disp_valid), 32'(m_valid));
    check("bcd_err", 32'(bcd_err), 32'(m_err));
  endtask

  task automatic load_digits(input int h, input int t, input int o);
    hundreds = 4'(h); tens = 4'(t); ones = 4'(o);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Advance until the DUT state (model phase) lies in [lo,hi]; bounded.
  task automatic wait_phase(input int lo, input int hi);
    int k;
    k = 0;
    while (k < 40 && !(m_active && (m_j % P) >= lo && (m_j % P) <= hi)) begin
      tick();
      k++;
    end
    check("phase_reached", 32'(m_active && (m_j % P) >= lo && (m_j % P) <= hi), 32'd1);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; clr = 1'b0;
    ones = 4'd0; tens = 4'd0; hundreds = 4'd0;
    model_reset();
    #3;
    check("rst_an", 32'(an), 32'h7);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_valid", 32'(disp_valid), 32'd0);
    check("rst_err", 32'(bcd_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    tick(); tick();

    // 1/2/3: explicit anode sequence plus model checks
    load_digits(1, 2, 3);
    for (int i = 0; i < 18; i++) begin
      tick();
      check("an_seq", 32'(an), 32'(exp_an_seq[i]));
    end
    for (int i = 0; i < 18; i++) tick();

    // invalid hundreds digit, then a valid load clears the error
    load_digits(12, 0, 5);
    for (int i = 0; i < 20; i++) tick();
    load_digits(4, 5, 6);
    for (int i = 0; i < 20; i++) tick();

    // clr and load together during SHOW1
    wait_phase(S, S + R - 1);
    hundreds = 4'd9; tens = 4'd9; ones = 4'd9;
    clr = 1'b1; load = 1'b1;
    tick();
    clr = 1'b0; load = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // second load in the middle of SHOW1
    load_digits(5, 6, 7);
    wait_phase(S + 1, S + 1);
    load_digits(8, 3, 2);
    for (int i = 0; i < 20; i++) tick();

    // leading zeros
    load_digits(0, 0, 7);
    for (int i = 0; i < 20; i++) tick();
    load_digits(0, 4, 1);
    for (int i = 0; i < 20; i++) tick();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      ones     = 4'($urandom_range(0, 15));
      tens     = 4'($urandom_range(0, 15));
      hundreds = 4'($urandom_range(0, 15));
      load     = ($urandom_range(0, 15) == 0);
      clr      = ($urandom_range(0, 63) == 0);
      tick();
    end
    load = 1'b0; clr = 1'b0;

    // asynchronous reset between edges during SHOW2
    if (!m_active) load_digits(3, 2, 1);
    wait_phase(2 * S, 2 * S + R - 1);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_an", 32'(an), 32'h7);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_valid", 32'(disp_valid), 32'd0);
    hundreds = 4'd1; tens = 4'd1; ones = 4'd1;
    load = 1'b1;
    tick();
    load = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    load_digits(9, 8, 7);
    for (int i = 0; i < 18; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 50000, meaning cycles each digit is lit per slot; legal range 4..2^20.
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning all-anodes-off dead time between slots; legal range 1..REFRESH_CYCLES-1.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port load  input  1  one-cycle capture strobe, driven by the upstream converter's done.
REQ-006 SHALL have port ones  input  4  BCD ones digit.
REQ-007 SHALL have port tens  input  4  BCD tens digit.
REQ-008 SHALL have port hundreds  input  4  BCD hundreds digit.
REQ-009 SHALL have port clr  input  1  synchronous blank/clear request.
REQ-010 SHALL have port seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-011 SHALL have port an  output  3  digit anodes {hundreds,tens,ones}, active-low, registered.
REQ-012 SHALL have port disp_valid  output  1  shadow registers hold captured data.
REQ-013 SHALL have port bcd_err  output  1  last capture contained a digit greater than 9.

Function
REQ-014 SHALL capture ones/tens/hundreds into shadow registers at the edge where load=1 is sampled, and set disp_valid=1 and bcd_err=(any digit >9) at that same edge.
REQ-015 SHALL implement FSM states IDLE, SHOW0, GAP0, SHOW1, GAP1, SHOW2, GAP2, where SHOWn lights digit n (0=ones, 1=tens, 2=hundreds).
REQ-016 SHALL transition IDLE->SHOW0 on load with the cycle counter cleared.
REQ-017 SHALL remain in SHOWn for exactly REFRESH_CYCLES cycles, then enter GAPn.
REQ-018 SHALL remain in GAPn for exactly GAP_CYCLES cycles, then enter SHOW((n+1) mod 3), wrapping GAP2->SHOW0.
REQ-019 SHALL NOT restart the scan, or alter state or counter, when load arrives outside IDLE; new shadow data appears on the next registered output update.
REQ-020 SHALL drive an=3'b111 and seg=7'h7F in IDLE and in every GAP state.
REQ-021 SHALL register seg/an one cycle after the state/shadow values they decode: load at edge E0 gives an=3'b110 with the ones pattern at edge E1.
REQ-022 SHALL decode digits 0..9 as 40,79,24,30,19,12,02,78,00,10 (hex, seg[6:0]).
REQ-023 SHALL decode values 10..15 as 7'h3F (dash, only g lit).
REQ-024 SHALL, on clr=1, enter IDLE, clear the counter and disp_valid, and clear bcd_err.
REQ-025 SHALL give clr priority over load when both are asserted in the same cycle; no capture occurs.
REQ-026 SHALL size the cycle counter at $clog2(REFRESH_CYCLES) bits and never let it exceed REFRESH_CYCLES-1.

Reset
REQ-027 SHALL, on reset assertion and independent of clk, set state=IDLE, counter=0, shadows=0, seg=7'h7F, an=3'b111, disp_valid=0, bcd_err=0.
REQ-028 SHALL, on reset asserted mid-scan, blank the outputs immediately and ignore load until reset deasserts.

Configuration
REQ-029 SHALL support macro BCD_DISP_LZB_EN for leading-zero blanking.
REQ-030 SHALL, with BCD_DISP_LZB_EN defined, hold an=3'b111 during SHOW2 when hundreds==0, and during SHOW1 when hundreds==0 and tens==0; the ones digit is never blanked, and slot timing is unchanged.
REQ-031 SHALL, without BCD_DISP_LZB_EN, light all three digits in their slots regardless of value.

Verification (REFRESH_CYCLES=4, GAP_CYCLES=2)
REQ-032 SHALL cover: reset, then load with 1/2/3 (hundreds/tens/ones) -> an sequence 110 x4, 111 x2, 101 x4, 111 x2, 011 x4, repeating; seg 30, 24, 79 in the respective slots; disp_valid=1.
REQ-033 SHALL cover: load with 0/0/7 and BCD_DISP_LZB_EN defined -> only the ones slot lights (seg=78); tens and hundreds slots keep an=111. Without the macro -> seg=40 in the tens and hundreds slots.
REQ-034 SHALL cover: load with hundreds=4'hC -> bcd_err=1 and seg=3F in the hundreds slot; a later load with valid digits -> bcd_err=0.
REQ-035 SHALL cover: load and clr in the same cycle during SHOW1 -> IDLE next cycle, an=111, disp_valid=0, shadows unchanged.
REQ-036 SHALL cover: a second load mid-SHOW1 with new digits -> slot length unchanged (4 cycles) and the new tens pattern visible one cycle later.
REQ-037 SHALL cover: reset pulse between clock edges during SHOW2 -> an=111, seg=7F immediately; no output until the next load.
